// File: rtl/pmp_tor_match.sv
// Registered PMP Top-Of-Range matcher for one entry: flags accesses of 1-4 bytes fully inside [addr_n_1, addr_n).
// Optional macro TOR_PARTIAL_EN adds tor_partial, flagging accesses that straddle the region edge.
module pmp_tor_match #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    input  logic [XLEN-1:0] addr,
    input  logic [1:0]      size,
    input  logic [XLEN-1:0] addr_n_1,
    input  logic [XLEN-1:0] addr_n,
    output logic            out_valid,
`ifdef TOR_PARTIAL_EN
    output logic            tor_partial,
`endif
    output logic            tor_out
);

    logic [XLEN:0] last_s;
    logic          region_ok_s;
    logic          m_full_s;
    logic          out_valid_d;
    logic          out_valid_q;
    logic          tor_out_d;
    logic          tor_out_q;
`ifdef TOR_PARTIAL_EN
    logic          overlap_s;
    logic          tor_partial_d;
    logic          tor_partial_q;
`endif

    // Match evaluation; the extra MSB of last_s keeps a carry out of the top address from wrapping.
    always_comb begin
        last_s      = {1'b0, addr} + {{(XLEN-1){1'b0}}, size};
        region_ok_s = (addr_n > addr_n_1);
        m_full_s    = region_ok_s && (addr >= addr_n_1) && (last_s < {1'b0, addr_n});
`ifdef TOR_PARTIAL_EN
        overlap_s   = region_ok_s && (addr < addr_n) && (last_s >= {1'b0, addr_n_1});
`endif
    end

    // Next-state; gating on req_valid keeps idle-cycle input junk out of the result.
    always_comb begin
        out_valid_d = req_valid;
        tor_out_d   = 1'b0;
`ifdef TOR_PARTIAL_EN
        tor_partial_d = 1'b0;
`endif
        if (req_valid) begin
            tor_out_d = m_full_s;
`ifdef TOR_PARTIAL_EN
            tor_partial_d = overlap_s && !m_full_s;
`endif
        end else begin
            tor_out_d = 1'b0;
`ifdef TOR_PARTIAL_EN
            tor_partial_d = 1'b0;
`endif
        end
    end

    // Output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            tor_out_q   <= 1'b0;
`ifdef TOR_PARTIAL_EN
            tor_partial_q <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            tor_out_q   <= tor_out_d;
`ifdef TOR_PARTIAL_EN
            tor_partial_q <= tor_partial_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign tor_out   = tor_out_q;
`ifdef TOR_PARTIAL_EN
    assign tor_partial = tor_partial_q;
`endif

endmodule

// File: tb/tb_pmp_tor_match.sv
// Self-checking bench for pmp_tor_match: directed plan plus randomized accesses against a 64-bit arithmetic model.
module tb_pmp_tor_match;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] addr_n_1;
    logic [31:0] addr_n;
    logic        out_valid;
    logic        tor_out;
`ifdef TOR_PARTIAL_EN
    logic        tor_partial;
`endif

    int tests;
    int fails;

    pmp_tor_match #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .addr      (addr),
        .size      (size),
        .addr_n_1  (addr_n_1),
        .addr_n    (addr_n),
        .out_valid (out_valid),
`ifdef TOR_PARTIAL_EN
        .tor_partial (tor_partial),
`endif
        .tor_out   (tor_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the access covers bytes a .. a+s as plain integers, no wrap possible in 64 bits.
    function automatic logic model_full(input logic v, input logic [31:0] a, input logic [1:0] s,
                                        input logic [31:0] lo, input logic [31:0] hi);
        longint unsigned first_b, last_b;
        first_b = longint'(a);
        last_b  = first_b + longint'(s);
        return v && (first_b >= longint'(lo)) && (last_b < longint'(hi));
    endfunction

    function automatic logic model_partial(input logic v, input logic [31:0] a, input logic [1:0] s,
                                           input logic [31:0] lo, input logic [31:0] hi);
        longint unsigned first_b, last_b;
        logic any_byte_in;
        first_b = longint'(a);
        last_b  = first_b + longint'(s);
        any_byte_in = 1'b0;
        for (longint unsigned b = first_b; b <= last_b; b++)
            if (b >= longint'(lo) && b < longint'(hi)) any_byte_in = 1'b1;
        return v && any_byte_in && !model_full(v, a, s, lo, hi);
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic v, input logic [31:0] a, input logic [1:0] s,
                        input logic [31:0] lo, input logic [31:0] hi);
        logic e_full, e_part;
        @(negedge clk);
        req_valid = v;
        addr      = a;
        size      = s;
        addr_n_1  = lo;
        addr_n    = hi;
        e_full = model_full(v, a, s, lo, hi);
        e_part = model_partial(v, a, s, lo, hi);
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, out_valid, v);
        chk({tag, ".tor"}, tor_out, e_full);
`ifdef TOR_PARTIAL_EN
        chk({tag, ".partial"}, tor_partial, e_part);
`endif
    endtask

    initial begin
        logic [31:0] lo, hi, a;
        logic [1:0]  s;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        addr = 32'h0;
        size = 2'd0;
        addr_n_1 = 32'h0;
        addr_n = 32'h0;
        #12;
        chk("reset.valid", out_valid, 1'b0);
        chk("reset.tor", tor_out, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        step("r1_0fff", 1'b1, 32'h0000_0FFF, 2'd0, 32'h1000, 32'h2000);
        step("r1_1000", 1'b1, 32'h0000_1000, 2'd0, 32'h1000, 32'h2000);
        step("r1_1001", 1'b1, 32'h0000_1001, 2'd0, 32'h1000, 32'h2000);
        step("r1_1fff", 1'b1, 32'h0000_1FFF, 2'd0, 32'h1000, 32'h2000);
        step("r1_2000", 1'b1, 32'h0000_2000, 2'd0, 32'h1000, 32'h2000);
        step("r1_2001", 1'b1, 32'h0000_2001, 2'd0, 32'h1000, 32'h2000);
        step("r1_s3_1ffc", 1'b1, 32'h0000_1FFC, 2'd3, 32'h1000, 32'h2000);
        step("r1_s3_1ffd", 1'b1, 32'h0000_1FFD, 2'd3, 32'h1000, 32'h2000);
        step("r1_s3_0ffe", 1'b1, 32'h0000_0FFE, 2'd3, 32'h1000, 32'h2000);

        for (int k = 0; k < 3; k++) begin
            s = (k == 0) ? 2'd0 : ((k == 1) ? 2'd1 : 2'd3);
            step("r2_3000", 1'b1, 32'h0000_3000, s, 32'h3000, 32'h4000);
            step("r2_3064", 1'b1, 32'h0000_3064, s, 32'h3000, 32'h4000);
            step("r2_4000", 1'b1, 32'h0000_4000, s, 32'h3000, 32'h4000);
            step("r2_3fff", 1'b1, 32'h0000_3FFF, s, 32'h3000, 32'h4000);
        end

        step("full_0", 1'b1, 32'h0, 2'd0, 32'h0, 32'hFFFF_FFFF);
        step("full_100", 1'b1, 32'h100, 2'd3, 32'h0, 32'hFFFF_FFFF);
        for (int k = 0; k < 4; k++) begin
            s = 2'(k);
            step("full_top", 1'b1, 32'hFFFF_FFFF, s, 32'h0, 32'hFFFF_FFFF);
            step("top_bound", 1'b1, 32'hFFFF_FFFF, s, 32'h0, 32'hFFFF_FFFF);
            step("empty_0", 1'b1, 32'h0, s, 32'h0, 32'h0);
            step("empty_100", 1'b1, 32'h100, s, 32'h0, 32'h0);
            step("empty_top", 1'b1, 32'hFFFF_FFFF, s, 32'h0, 32'h0);
            step("inverted", 1'b1, 32'h1800, s, 32'h2000, 32'h1000);
        end
        step("full_fffe_s3", 1'b1, 32'hFFFF_FFFE, 2'd3, 32'h0, 32'hFFFF_FFFF);
        step("wrap_region", 1'b1, 32'hFFFF_FFFE, 2'd3, 32'hFFFF_FF00, 32'hFFFF_FFFF);

        step("gate_in_range", 1'b0, 32'h0000_1800, 2'd0, 32'h1000, 32'h2000);
        step("gate_x_addr", 1'b0, 32'hxxxx_xxxx, 2'bxx, 32'h1000, 32'h2000);

        // Asynchronous reset between edges while a match is held.
        step("pre_rst", 1'b1, 32'h0000_1800, 2'd1, 32'h1000, 32'h2000);
        chk("pre_rst.held", tor_out, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.tor", tor_out, 1'b0);
        chk("async_rst.valid", out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1'b1, 32'h0000_1000, 2'd3, 32'h1000, 32'h2000);

        for (int n = 0; n < 300; n++) begin
            lo = $urandom;
            hi = ($urandom_range(0, 3) == 0) ? 32'($urandom) : lo + 32'($urandom_range(0, 40));
            case ($urandom_range(0, 3))
                0: a = lo - 32'($urandom_range(0, 4));
                1: a = hi - 32'($urandom_range(0, 5));
                2: a = lo + 32'($urandom_range(0, 40));
                default: a = $urandom;
            endcase
            s = 2'($urandom_range(0, 3));
            step("rand", ($urandom_range(0, 7) != 0), a, s, lo, hi);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pmp_tor_match.md
Name: pmp_tor_match

Overview:
- Registered PMP Top-Of-Range (TOR) address matcher for one PMP entry.
- Decides whether a whole access of 1–4 bytes lies inside the half-open region [addr_n_1, addr_n).
- addr_n_1 is the previous entry's pmpaddr; addr_n is this entry's pmpaddr. Both are full byte addresses.
- Sits in the PMP checker, one instance per entry. Its match output feeds the priority/permission logic.

Parameters:
- XLEN, 32, width of the access address and both bound addresses.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  access request present this cycle
- addr  in  XLEN  byte address of the first byte accessed
- size  in  2  access span minus one (0=1 byte, 1=2 bytes, 2=3 bytes, 3=4 bytes)
- addr_n_1  in  XLEN  region lower bound, inclusive
- addr_n  in  XLEN  region upper bound, exclusive
- out_valid  out  1  registered copy of req_valid
- tor_out  out  1  registered full-containment match

Behaviour:
- Last byte of the access: last = addr + size, computed XLEN+1 bits wide (zero-extended). It must never wrap.
- All comparisons are unsigned.
- Combinational match m_full = (addr >= addr_n_1) AND (last < addr_n).
- Upper bound is exclusive. An access touching byte addr_n does not match.
- Empty or inverted region (addr_n <= addr_n_1): m_full = 0 for every addr and size.
- Access running past 2^XLEN-1 (carry out of last): m_full = 0.
- addr = 2^XLEN-1 never matches, even with addr_n = 2^XLEN-1, because the bound is exclusive.
- Latency is 1 cycle.
  - On each rising clk: out_valid <= req_valid; tor_out <= req_valid & m_full.
  - When req_valid = 0, tor_out registers 0.
- Bounds and size are sampled in the same cycle as addr. A bound change takes effect on the next registered result; there is no hold-off.
- No handshake or backpressure. A new request may be accepted every cycle.
- Reset: asserting rst_n = 0 immediately clears out_valid, tor_out and tor_partial (when present) to 0, even mid-request.
- First registered result appears on the first rising edge after rst_n deasserts.
- No internal state beyond the output registers.
- X on an input when req_valid = 0 must not propagate to tor_out.

Optional Feature:
- Macro TOR_PARTIAL_EN.
- When defined, adds output tor_partial (1 bit, registered, same latency and reset as tor_out).
  - tor_partial = req_valid AND (access overlaps the region in at least one byte) AND NOT m_full.
  - Overlap means: addr < addr_n AND last >= addr_n_1, with the region non-empty. last uses the same XLEN+1-bit value as above.
  - Lets the checker flag straddling accesses as faults.
- When undefined, the port and its logic are absent; tor_out behaviour is unchanged.

Test Plan:
- Region 0x1000–0x2000, size 0, req_valid = 1:
  - addr 0x0FFF -> tor_out 0
  - addr 0x1000 -> 1
  - addr 0x1001 -> 1
  - addr 0x1FFF -> 1
  - addr 0x2000 -> 0
  - addr 0x2001 -> 0
  - Each result one cycle later, out_valid = 1.
- Same region, size 3:
  - addr 0x1FFC -> 1
  - addr 0x1FFD -> 0 (tor_partial 1 with TOR_PARTIAL_EN)
  - addr 0x0FFE -> 0 (tor_partial 1)
- Region 0x3000–0x4000, sizes 0/1/3:
  - addr 0x3000 -> 1
  - addr 0x3064 -> 1
  - addr 0x4000 -> 0
  - addr 0x3FFF -> 1 only for size 0
- Region 0x0–0xFFFFFFFF:
  - addr 0x0 -> 1
  - addr 0x100 -> 1
  - addr 0xFFFFFFFF -> 0 for all sizes
  - addr 0xFFFFFFFE size 3 -> 0 (no wrap)
- Region 0x0–0x0 (empty), any size:
  - addr 0x0, 0x100, 0xFFFFFFFF -> tor_out 0, tor_partial 0
- Reset and valid gating:
  - rst_n pulled low between edges while tor_out = 1 -> tor_out and out_valid drop to 0 immediately.
  - req_valid = 0 with an in-range addr -> tor_out 0 next cycle.
